// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants and FSM state type for the feedback gain/gate stage
// Contents:
//   FB_GAIN_FRAC : default number of fractional gain bits (Q2.14)
//   FB_DAC_W     : kicker DAC word width, shared with the DAC interface
//   fb_state_t   : window FSM state encoding
package fb_pkg;

    localparam int FB_GAIN_FRAC = 14;
    localparam int FB_DAC_W     = 14;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FLUSH  = 2'd3
    } fb_state_t;

endpackage

// File: rtl/fb_gain_gate_if.sv
// rtl/fb_gain_gate_if.sv - control, sample and output bundle of the feedback gain/gate stage
// Signals:
//   enable, trig            : arm and beam trigger
//   start_dly, win_len      : window placement (cycles) and length (samples)
//   gain, din               : Q2.14 gain and signed delayed sample
//   dout, active, done      : gated DAC word, window gate, completion pulse
//   sat_flag                : sticky saturation indicator
// Modports: master drives the controls/samples, slave is the gain/gate stage.
interface fb_gain_gate_if
    import fb_pkg::*;
#(
    parameter int OUT_W = FB_DAC_W
) ();

    logic                    enable;
    logic                    trig;
    logic [7:0]              start_dly;
    logic [7:0]              win_len;
    logic signed [15:0]      gain;
    logic signed [15:0]      din;
    logic signed [OUT_W-1:0] dout;
    logic                    active;
    logic                    done;
    logic                    sat_flag;

    modport master (
        output enable, trig, start_dly, win_len, gain, din,
        input  dout, active, done, sat_flag
    );

    modport slave (
        input  enable, trig, start_dly, win_len, gain, din,
        output dout, active, done, sat_flag
    );

endinterface

// File: rtl/fb_round_sat.sv
// rtl/fb_round_sat.sv - combinational round-half-up and clamp of a fixed-point product
// Ports:
//   i_p   in  32        signed product with GAIN_FRAC fractional bits
//   o_q   out OUT_W     rounded, clamped signed result
//   o_ovf out 1         high when the rounded value was clamped
module fb_round_sat #(
    parameter int OUT_W     = 14,
    parameter int GAIN_FRAC = 14
) (
    input  logic signed [31:0]      i_p,
    output logic signed [OUT_W-1:0] o_q,
    output logic                    o_ovf
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam logic signed [32:0] RND  = 33'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

    logic signed [32:0] w_sum;
    logic signed [32:0] w_r;

    always_comb begin
        w_sum = {i_p[31], i_p} + RND;
        w_r   = w_sum >>> GAIN_FRAC;
        if (w_r > MAXV) begin
            o_q   = MAXV[OUT_W-1:0];
            o_ovf = 1'b1;
        end else if (w_r < MINV) begin
            o_q   = MINV[OUT_W-1:0];
            o_ovf = 1'b1;
        end else begin
            o_q   = w_r[OUT_W-1:0];
            o_ovf = 1'b0;
        end
    end

endmodule

// File: rtl/fb_gain_gate.sv
// rtl/fb_gain_gate.sv - trigger-windowed gain, round/saturate and gate for the kicker DAC word
// Ports:
//   clk    in  1   system clock
//   rst_n  in  1   asynchronous active-low reset
//   bus    slave   fb_gain_gate_if: enable, trig, start_dly, win_len, gain, din in;
//                  dout, active, done, sat_flag out
// Data path is two registers deep: stage 1 holds product and gate, stage 2 holds
// the rounded/clamped/gated word.
module fb_gain_gate
    import fb_pkg::*;
#(
    parameter int OUT_W     = FB_DAC_W,
    parameter int GAIN_FRAC = FB_GAIN_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    fb_gain_gate_if.slave bus
);

    fb_state_t               r_state;
    logic [7:0]              r_cnt;
    logic [7:0]              r_win_len;
    logic signed [15:0]      r_gain;
    logic                    r_trig_d;
    logic                    r_done;

    logic signed [31:0]      r_prod;
    logic                    r_gate1;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_active;
    logic                    r_sat;

    logic                    w_accept;
    logic                    w_gate_en;
    logic signed [OUT_W-1:0] w_clamped;
    logic                    w_ovf;

    // The done cycle itself is still treated as busy, so the earliest new
    // window starts the cycle after done.
    assign w_accept  = bus.trig && !r_trig_d && bus.enable &&
                       (r_state == ST_IDLE) && !r_done;
    assign w_gate_en = (r_state == ST_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_win_len <= 8'd0;
            r_gain    <= 16'sd0;
            r_trig_d  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_trig_d <= bus.trig;
            r_done   <= 1'b0;
            if (r_state != ST_IDLE && !bus.enable) begin
                // Abort: no done pulse; samples already in the pipe drain on their own.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_gain    <= bus.gain;
                            r_win_len <= bus.win_len;
                            if (bus.start_dly != 8'd0) begin
                                r_state <= ST_WAIT;
                                r_cnt   <= bus.start_dly;
                            end else if (bus.win_len != 8'd0) begin
                                r_state <= ST_ACTIVE;
                                r_cnt   <= bus.win_len;
                            end else begin
                                r_state <= ST_FLUSH;
                                r_cnt   <= 8'd2;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (r_cnt == 8'd1) begin
                            if (r_win_len != 8'd0) begin
                                r_state <= ST_ACTIVE;
                                r_cnt   <= r_win_len;
                            end else begin
                                r_state <= ST_FLUSH;
                                r_cnt   <= 8'd2;
                            end
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (r_cnt == 8'd1) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= 8'd2;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_cnt == 8'd1) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    fb_round_sat #(
        .OUT_W     (OUT_W),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_round_sat (
        .i_p   (r_prod),
        .o_q   (w_clamped),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod   <= 32'sd0;
            r_gate1  <= 1'b0;
            r_dout   <= '0;
            r_active <= 1'b0;
            r_sat    <= 1'b0;
        end else begin
            r_prod   <= $signed({{16{bus.din[15]}}, bus.din}) *
                        $signed({{16{r_gain[15]}}, r_gain});
            r_gate1  <= w_gate_en;
            r_dout   <= r_gate1 ? w_clamped : '0;
            r_active <= r_gate1;
            // Clear has priority: no gated sample belongs to the new window yet.
            if (w_accept) begin
                r_sat <= 1'b0;
            end else if (r_gate1 && w_ovf) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign bus.dout     = r_dout;
    assign bus.active   = r_active;
    assign bus.done     = r_done;
    assign bus.sat_flag = r_sat;

endmodule

// File: tb/tb_fb_gain_gate.sv
// tb/tb_fb_gain_gate.sv - scoreboard bench for fb_gain_gate against a window/arithmetic model
module tb_fb_gain_gate;

    localparam int OUT_W = 14;
    localparam int GF    = 14;

    typedef struct {
        int dout;
        bit active;
        bit done;
        bit sat;
    } exp_t;

    logic clk;
    logic rst_n;

    fb_gain_gate_if #(.OUT_W(OUT_W)) bus ();

    fb_gain_gate #(.OUT_W(OUT_W), .GAIN_FRAC(GF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    bit   mon_on   = 0;
    exp_t sb[$];

    bit                 s_en, s_trig;
    logic [7:0]         s_sd, s_wl;
    logic signed [15:0] s_gain, s_din;

    bit                 m_prev_trig, m_busy, m_sat, p_gate, p_clamp;
    int                 m_gs, m_ge, m_end, m_done_cyc, p_val;
    logic signed [15:0] m_gain;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic: full product, round half up, clamp to the DAC range.
    task automatic ref_scale(input logic signed [15:0] d, input logic signed [15:0] g,
                             output int v, output bit c);
        longint p, r, lo, hi;
        p  = longint'(d) * longint'(g);
        r  = (p + (longint'(1) << (GF - 1))) >>> GF;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        c  = (r > hi) || (r < lo);
        v  = (r > hi) ? int'(hi) : (r < lo) ? int'(lo) : int'(r);
    endtask

    task automatic model_reset();
        m_prev_trig = 0; m_busy = 0; m_sat = 0; p_gate = 0; p_clamp = 0;
        m_gs = 0; m_ge = -1; m_end = -1; m_done_cyc = -1; p_val = 0; m_gain = 16'sd0;
    endtask

    // One cycle: drive inputs, advance the window model, queue what the DUT
    // must show in the following cycle.
    task automatic tick();
        bit   gate, nonidle, idle, accept, clamp;
        int   val;
        exp_t e;
        @(negedge clk);
        bus.enable    = s_en;
        bus.trig      = s_trig;
        bus.start_dly = s_sd;
        bus.win_len   = s_wl;
        bus.gain      = s_gain;
        bus.din       = s_din;

        gate    = m_busy && (cyc >= m_gs) && (cyc <= m_ge);
        ref_scale(s_din, m_gain, val, clamp);
        nonidle = m_busy && (cyc <= m_end);
        if (nonidle && !s_en) begin
            m_end = cyc;
            if (m_ge > cyc) m_ge = cyc;
            m_done_cyc = -1;
        end
        idle   = !nonidle && (cyc != m_done_cyc);
        accept = s_trig && !m_prev_trig && s_en && idle;
        if (accept) m_sat = 0;
        else if (p_gate && p_clamp) m_sat = 1;
        if (accept) begin
            m_busy     = 1;
            m_gain     = s_gain;
            m_gs       = cyc + 1 + int'(s_sd);
            m_ge       = cyc + int'(s_sd) + int'(s_wl);
            m_end      = cyc + 2 + int'(s_sd) + int'(s_wl);
            m_done_cyc = cyc + 3 + int'(s_sd) + int'(s_wl);
        end
        e.dout   = p_gate ? p_val : 0;
        e.active = p_gate;
        e.done   = (cyc + 1 == m_done_cyc);
        e.sat    = m_sat;
        sb.push_back(e);
        p_gate      = gate;
        p_val       = val;
        p_clamp     = clamp;
        m_prev_trig = s_trig;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            s_din = 16'($urandom);
            tick();
        end
    endtask

    task automatic fire(input logic [7:0] sd, input logic [7:0] wl, input logic signed [15:0] g);
        s_sd = sd; s_wl = wl; s_gain = g; s_trig = 1;
        s_din = 16'($urandom);
        tick();
        s_trig = 0;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_on && sb.size() > 0) begin
            e = sb.pop_front();
            chk("dout", bus.dout, e.dout);
            chk("active", {31'd0, bus.active}, {31'd0, e.active});
            chk("done", {31'd0, bus.done}, {31'd0, e.done});
            chk("sat_flag", {31'd0, bus.sat_flag}, {31'd0, e.sat});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_en = 0; s_trig = 0; s_sd = 0; s_wl = 0; s_gain = 0; s_din = 0;
        bus.enable = 0; bus.trig = 0; bus.start_dly = 0; bus.win_len = 0;
        bus.gain = 0; bus.din = 0;
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        chk("reset_dout", bus.dout, 0);
        chk("reset_active", {31'd0, bus.active}, 0);
        chk("reset_done", {31'd0, bus.done}, 0);
        chk("reset_sat", {31'd0, bus.sat_flag}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        model_reset();
        mon_on = 1;
        s_en = 1;
        ticks(3);

        // Unity gain, ramp input, start 2 / length 3.
        s_sd = 2; s_wl = 3; s_gain = 16384;
        for (int i = 0; i < 14; i++) begin
            s_din  = 16'(i);
            s_trig = (i == 0);
            tick();
        end
        s_trig = 0;

        // Rounding at gain 0.5.
        fire(0, 3, 16'sd8192);
        s_din = 3;     tick();
        s_din = -3;    tick();
        s_din = -1000; tick();
        ticks(5);

        // Saturation both ways, then a window that clears the flag.
        fire(0, 2, 16'sd16384);
        s_din = 32767;  tick();
        s_din = -32768; tick();
        ticks(5);
        fire(1, 1, -16'sd32768);
        s_din = 1; tick();
        s_din = -32768; tick();
        ticks(5);
        fire(1, 2, 16'sd100);
        ticks(8);

        // Zero start delay with one sample, then an empty window.
        fire(0, 1, 16'sd16384);
        ticks(6);
        fire(3, 0, 16'sd16384);
        ticks(8);

        // Second rise during WAIT, long trig hold, trig with enable low.
        fire(4, 3, 16'sd20000);
        ticks(1);
        s_trig = 1; ticks(1); s_trig = 0;
        ticks(10);
        s_sd = 0; s_wl = 2; s_gain = 16'sd12000; s_trig = 1;
        ticks(10);
        s_trig = 0;
        ticks(3);
        s_en = 0; s_trig = 1; ticks(1);
        s_en = 1; ticks(3); s_trig = 0;
        ticks(6);

        // Abort mid-ACTIVE.
        fire(1, 6, 16'sd16384);
        ticks(3);
        s_en = 0; ticks(2);
        s_en = 1; ticks(8);

        // Asynchronous reset inside a saturating window.
        fire(0, 8, 16'sd16384);
        s_din = 32767;
        for (int i = 0; i < 4; i++) tick();
        @(posedge clk);
        #3;
        mon_on = 0;
        rst_n  = 0;
        #1;
        chk("rst_mid_dout", bus.dout, 0);
        chk("rst_mid_active", {31'd0, bus.active}, 0);
        chk("rst_mid_done", {31'd0, bus.done}, 0);
        chk("rst_mid_sat", {31'd0, bus.sat_flag}, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        model_reset();
        mon_on = 1;
        ticks(2);
        fire(2, 2, 16'sd16384);
        ticks(8);

        // Randomized traffic: sparse triggers, occasional enable drops.
        for (int i = 0; i < 2500; i++) begin
            s_en   = ($urandom_range(0, 99) != 0);
            s_trig = ($urandom_range(0, 11) == 0);
            s_sd   = 8'($urandom_range(0, 6));
            s_wl   = 8'($urandom_range(0, 6));
            s_gain = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16384));
            s_din  = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4000) - 2000);
            tick();
        end
        s_trig = 0; s_en = 1;
        ticks(20);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_gain_gate.md
# fb_gain_gate

Downstream stage of the variable-tap feedback delay line. Takes the delayed signed 16-bit sample, multiplies it by a signed feedback gain, rounds and saturates it to the DAC word width, and gates it to zero outside a trigger-relative output window. The result drives the kicker DAC word.

## Interface
Parameters:
- OUT_W, 14: output word width, signed. Valid range is 8..16.
- GAIN_FRAC, 14: number of fractional bits in `gain`. 16384 represents 1.0.

Ports:
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  arms the block. Low ignores triggers and aborts an open window.
- trig  in  1  beam trigger. Rising edge is detected internally.
- start_dly  in  8  cycles from trigger acceptance to window open
- win_len  in  8  window length in samples
- gain  in  16  signed gain, Q2.14
- din  in  16  signed sample from the delay line, valid every cycle
- dout  out  OUT_W  signed gated output; reset 0
- active  out  1  window gate, aligned to `dout`; reset 0
- done  out  1  one-cycle pulse when a window completes; reset 0
- sat_flag  out  1  sticky saturation indicator; reset 0

## Operation
- **Edge detect:** `trig_d` is `trig` registered. A trigger is accepted at cycle T when all of these hold: `trig` is high, `trig_d` is low, `enable` is high, and the FSM is IDLE.
- **Latching:** `start_dly`, `win_len` and `gain` are latched at T. Input changes afterwards do not affect the current window.
- **FSM states:** IDLE, WAIT, ACTIVE, FLUSH.
  - IDLE → WAIT on trigger acceptance, with the counter loaded to `start_dly`.
  - IDLE → ACTIVE directly if `start_dly` = 0.
  - WAIT: the counter decrements; WAIT → ACTIVE when it reaches 0.
  - ACTIVE: lasts `win_len` cycles, then → FLUSH.
  - If `win_len` = 0, ACTIVE is skipped and the FSM goes straight to FLUSH.
  - FLUSH: lasts 2 cycles to drain the pipeline, then → IDLE with `done` high on the exit cycle.
- **Internal gate:** `gate_en` is 1 only in ACTIVE, so it is high for cycles T+1+start_dly through T+start_dly+win_len.
- **Triggers while busy:** a trigger arriving outside IDLE is ignored. It is not queued.
- **Abort:** `enable` low in any non-IDLE state forces IDLE on the next cycle. No `done` pulse is produced. The in-flight gated samples drain normally.
- **Arithmetic:**
  - Product p = din × gain_latched, 32-bit signed.
  - Rounded r = (p + 2^(GAIN_FRAC−1)) >>> GAIN_FRAC. This is arithmetic shift, round-half-up.
  - Clamp r to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **Output:** `dout` = clamped r when the delayed `gate_en` is 1, otherwise 0.
- **sat_flag:**
  - Set when a gated sample clamps.
  - Cleared on trigger acceptance.
  - If set and clear coincide, the clear wins, because no gated sample exists at T.
- **Reset:** asserting `rst_n` low at any time, including mid-window, asynchronously zeroes all state, all outputs and `trig_d`, and returns the FSM to IDLE.

## Timing
- Data latency is 2 cycles.
  - Stage 1 registers the product and `gate_en`.
  - Stage 2 registers round, saturate and gate into `dout`/`active`.
- `din` sampled at cycle k appears on `dout` at k+2, gated by `gate_en` at cycle k.
- Non-zero `dout` and `active` high occupy cycles T+3+start_dly through T+2+start_dly+win_len.
- `done` pulses at T+3+start_dly+win_len. This equals T+3+start_dly when `win_len` = 0.
- The earliest next accepted trigger is the cycle after `done`.
- There is no backpressure; `din` is consumed every cycle.

## Structure
- **Package `fb_pkg`:**
  - GAIN_FRAC default constant.
  - FSM state enum (IDLE, WAIT, ACTIVE, FLUSH), 2 bits.
  - DAC width constant shared with the DAC interface.
- **Sub-module `fb_round_sat`:** purely combinational round-and-clamp (32-bit in, OUT_W out, overflow flag out). It is instantiated in stage 2 and reusable elsewhere in the feedback path.

## Test plan
- **Unity gain, basic window:** gain=16384, start_dly=2, win_len=3, din ramp 0,1,2,…, trig rise at T.
  - `dout` equals the din values sampled at cycles T+3..T+5, on output cycles T+5..T+7.
  - `dout` is 0 elsewhere; `done` pulses at T+8.
- **Rounding:** gain=8192 (0.5), window open.
  - din 3 → 2; din −3 → −1; din −1000 → −500.
- **Saturation:** OUT_W=14, window open.
  - din 32767, gain 16384 → 8191, `sat_flag` set.
  - din −32768, gain −32768 → 8191.
  - din −32768, gain 16384 → −8192.
  - A subsequent accepted trigger clears `sat_flag`.
- **Zero cases:**
  - start_dly=0, win_len=1 → a single output sample at T+3; `done` at T+4.
  - win_len=0 → `dout` never non-zero; `done` at T+3+start_dly.
- **Trigger rejection:**
  - A second trig rise during WAIT/ACTIVE is ignored and window timing is unchanged.
  - trig held high for 10 cycles → one window only.
  - enable=0 at the trig rise → no window.
- **Abort/reset:**
  - enable drops mid-ACTIVE → `active` falls within 2 cycles and no `done`.
  - rst_n low mid-window → `dout`, `active`, `done` and `sat_flag` are 0 immediately (asynchronously) and the FSM is IDLE after release.
